// File: rtl/cpu_pkg.sv
// Shared CPU datapath types and constants.
// Used by the register file and its write-row decoder.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [31:0] reg_word_t;

endpackage

// File: rtl/decoder_5to32.sv
// One-hot row-enable decoder for the register file write port.
// Row 0 is never enabled so r0 stays hardwired to zero.
module decoder_5to32
    import cpu_pkg::*;
#(
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = 32
) (
    input  logic [ADDR_W-1:0]   w_addr,
    input  logic                en,
    output logic [NUM_REGS-1:0] row_en
);

    always_comb begin
        row_en         = '0;
        row_en[w_addr] = en;
        row_en[0]      = 1'b0;
    end

endmodule

// File: rtl/reg_file_2r1w.sv
// 32x32 register file: two combinational read ports, one synchronous write.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module reg_file_2r1w
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int ADDR_W   = cpu_pkg::ADDR_W,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic [15:0]       wr_count
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] row_en;
    logic                commit;

    decoder_5to32 #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_dec (
        .w_addr (w_addr),
        .en     (we),
        .row_en (row_en)
    );

    // Row 0 is masked in the decoder, so any set bit is a real write.
    assign commit = |row_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (row_en[i]) begin
                    regs[i] <= w_data;
                end
            end
            if (commit) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_ok;

    assign fwd_ok = rst_n && we && (w_addr != ZERO_A);

    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
        if (fwd_ok && (ra_addr == w_addr)) begin
            ra_data = w_data;
        end
        if (fwd_ok && (rb_addr == w_addr)) begin
            rb_data = w_data;
        end
        if (ra_addr == ZERO_A) begin
            ra_data = '0;
        end
        if (rb_addr == ZERO_A) begin
            rb_data = '0;
        end
    end
`else
    always_comb begin
        ra_data = regs[ra_addr];
        rb_data = regs[rb_addr];
        if (ra_addr == ZERO_A) begin
            ra_data = '0;
        end
        if (rb_addr == ZERO_A) begin
            rb_data = '0;
        end
    end
`endif

endmodule
